// File: rtl/audio_pkg.sv
// Shared audio definitions: voice arbiter FSM states, the default
// half-period width and note half-period codes used by the sequencers.
package audio_pkg;

  localparam int unsigned HP_W_DEF = 7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_GAP  = 2'd2
  } arb_state_e;

  // Half-period codes for the freq_synth voice (larger code = lower pitch).
  localparam logic [HP_W_DEF-1:0] NOTE_C4 = 7'd94;
  localparam logic [HP_W_DEF-1:0] NOTE_E4 = 7'd75;
  localparam logic [HP_W_DEF-1:0] NOTE_G4 = 7'd62;
  localparam logic [HP_W_DEF-1:0] NOTE_C5 = 7'd47;
  localparam logic [HP_W_DEF-1:0] NOTE_E5 = 7'd37;
  localparam logic [HP_W_DEF-1:0] NOTE_G5 = 7'd31;

endpackage

// File: rtl/voice_arbiter_if.sv
// Bundle between the note sources and the voice arbiter. The master side
// drives tick/req/hp_in; the slave (arbiter) drives grant/hp_out/active/busy.
interface voice_arbiter_if
  import audio_pkg::*;
#(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned HP_W  = HP_W_DEF
);

  logic                    tick;
  logic [N_REQ-1:0]        req;
  logic [N_REQ*HP_W-1:0]   hp_in;
  logic [N_REQ-1:0]        grant;
  logic [HP_W-1:0]         hp_out;
  logic                    active;
  logic                    busy;

  modport master (
    output tick, req, hp_in,
    input  grant, hp_out, active, busy
  );

  modport slave (
    input  tick, req, hp_in,
    output grant, hp_out, active, busy
  );

endinterface

// File: rtl/rr_pick.sv
// Combinational winner search: first set request at or after base_i,
// wrapping around. Masked requests are skipped unless the mask would
// leave nobody eligible, in which case the mask is ignored.
module rr_pick #(
  parameter int unsigned N     = 4,
  parameter int unsigned IDX_W = 2
) (
  input  logic [N-1:0]     req_i,
  input  logic [N-1:0]     mask_i,
  input  logic [IDX_W-1:0] base_i,
  output logic [N-1:0]     grant_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             valid_o
);

  logic [N-1:0]     cand;
  logic [IDX_W-1:0] pos;
  logic             found;

  // Rotating first-one search over the eligible request set
  always_comb begin
    cand    = req_i & ~mask_i;
    if (cand == '0) cand = req_i;
    grant_o = '0;
    idx_o   = '0;
    pos     = '0;
    found   = 1'b0;
    valid_o = |cand;
    for (int unsigned off = 0; off < N; off++) begin
      pos = IDX_W'((32'(base_i) + off) % N);
      if (!found && cand[pos]) begin
        found        = 1'b1;
        grant_o[pos] = 1'b1;
        idx_o        = pos;
      end
    end
  end

endmodule

// File: rtl/voice_arbiter.sv
// Shares one freq_synth voice among N_REQ note sources with minimum and
// maximum note lengths and a silent gap between notes.
// Build option: define VOICE_ARB_ROUND_ROBIN_EN for rotating priority;
// otherwise lowest index wins (the one-shot forced-release mask applies
// in both builds).
module voice_arbiter
  import audio_pkg::*;
#(
  parameter int unsigned N_REQ     = 4,
  parameter int unsigned HP_W      = HP_W_DEF,
  parameter int unsigned CTR_W     = 5,
  parameter int unsigned MIN_HOLD  = 2,
  parameter int unsigned MAX_HOLD  = 20,
  parameter int unsigned GAP_TICKS = 1
) (
  input logic            clk,
  input logic            rst,
  voice_arbiter_if.slave bus
);

  localparam int unsigned IDX_W = $clog2(N_REQ);

  if (N_REQ < 2 || N_REQ > 8) begin : g_bad_n_req
    $error("voice_arbiter: N_REQ must be 2..8");
  end
  if (MAX_HOLD < MIN_HOLD) begin : g_bad_hold
    $error("voice_arbiter: MAX_HOLD must be >= MIN_HOLD");
  end
  if (MAX_HOLD >= (1 << CTR_W) || GAP_TICKS >= (1 << CTR_W)) begin : g_bad_ctr_w
    $error("voice_arbiter: CTR_W too narrow for MAX_HOLD/GAP_TICKS");
  end

  arb_state_e       state_q, state_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [N_REQ-1:0] mask_q, mask_d;
  logic [IDX_W-1:0] owner_q, owner_d;
  logic [HP_W-1:0]  hp_q, hp_d;
  logic             active_q, active_d;
  logic             busy_q, busy_d;
  logic [CTR_W-1:0] hold_q, hold_d;
  logic [CTR_W-1:0] gap_q, gap_d;

  logic [HP_W-1:0]  hp_lane [N_REQ];
  logic [N_REQ-1:0] pick_grant;
  logic [IDX_W-1:0] pick_idx;
  logic [IDX_W-1:0] base;
  logic             pick_valid;
  logic [CTR_W-1:0] hold_inc;
  logic             owner_req;
  logic             others_req;
  logic             rel_natural;
  logic             rel_forced;

  for (genvar g = 0; g < N_REQ; g++) begin : g_lane
    assign hp_lane[g] = bus.hp_in[g*HP_W +: HP_W];
  end

`ifdef VOICE_ARB_ROUND_ROBIN_EN
  logic [IDX_W-1:0] rr_q, rr_d;

  // Pointer moves to the slot after each new owner
  always_comb begin
    rr_d = rr_q;
    if (state_q == ST_IDLE && pick_valid) begin
      rr_d = (pick_idx == IDX_W'(N_REQ - 1)) ? '0 : pick_idx + 1'b1;
    end
  end

  // Round-robin pointer register
  always_ff @(posedge clk) begin
    if (rst) rr_q <= '0;
    else     rr_q <= rr_d;
  end

  assign base = rr_q;
`else
  assign base = '0;
`endif

  rr_pick #(
    .N     (N_REQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .req_i   (bus.req),
    .mask_i  (mask_q),
    .base_i  (base),
    .grant_o (pick_grant),
    .idx_o   (pick_idx),
    .valid_o (pick_valid)
  );

  // Release decisions use the hold count after this cycle's tick
  always_comb begin
    hold_inc    = (bus.tick && hold_q < CTR_W'(MAX_HOLD)) ? hold_q + 1'b1 : hold_q;
    owner_req   = bus.req[owner_q];
    others_req  = |(bus.req & ~grant_q);
    rel_natural = !owner_req && (hold_inc >= CTR_W'(MIN_HOLD));
    rel_forced  = owner_req && others_req && (hold_inc >= CTR_W'(MAX_HOLD));
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    mask_d  = mask_q;
    owner_d = owner_q;
    hp_d    = hp_q;
    hold_d  = hold_q;
    gap_d   = gap_q;
    unique case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          grant_d = pick_grant;
          owner_d = pick_idx;
          hp_d    = hp_lane[pick_idx];
          hold_d  = '0;
          mask_d  = '0;
          state_d = ST_PLAY;
        end
      end
      ST_PLAY: begin
        hold_d = hold_inc;
        if (owner_req) hp_d = hp_lane[owner_q];
        if (rel_natural || rel_forced) begin
          grant_d = '0;
          hold_d  = '0;
          if (rel_forced) mask_d = grant_q;
          gap_d   = CTR_W'(GAP_TICKS);
          state_d = (GAP_TICKS == 0) ? ST_IDLE : ST_GAP;
        end
      end
      ST_GAP: begin
        if (bus.tick) begin
          if (gap_q <= CTR_W'(1)) begin
            gap_d   = '0;
            state_d = ST_IDLE;
          end else begin
            gap_d = gap_q - 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    active_d = (state_d == ST_PLAY);
    busy_d   = (state_d != ST_IDLE);
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      grant_q  <= '0;
      mask_q   <= '0;
      owner_q  <= '0;
      hp_q     <= '0;
      active_q <= 1'b0;
      busy_q   <= 1'b0;
      hold_q   <= '0;
      gap_q    <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      mask_q   <= mask_d;
      owner_q  <= owner_d;
      hp_q     <= hp_d;
      active_q <= active_d;
      busy_q   <= busy_d;
      hold_q   <= hold_d;
      gap_q    <= gap_d;
    end
  end

  assign bus.grant  = grant_q;
  assign bus.hp_out = hp_q;
  assign bus.active = active_q;
  assign bus.busy   = busy_q;

endmodule

// File: tb/tb_voice_arbiter.sv
// Directed bench for voice_arbiter with N_REQ=4, MIN_HOLD=2, MAX_HOLD=20,
// GAP_TICKS=1. Lanes 1..3 carry fixed half-periods 20/30/90.
module tb_voice_arbiter;
  import audio_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic [6:0] hp0;

  always #5 clk = ~clk;

  voice_arbiter_if #(.N_REQ(4), .HP_W(7)) bus ();

  voice_arbiter #(
    .N_REQ     (4),
    .HP_W      (7),
    .CTR_W     (5),
    .MIN_HOLD  (2),
    .MAX_HOLD  (20),
    .GAP_TICKS (1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  assign bus.hp_in = {7'd90, 7'd30, 7'd20, hp0};

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic       rst;
    logic       tick;
    logic [3:0] req;
    logic [6:0] hp0;
    logic [3:0] g;
    logic [6:0] hp;
    logic       act;
    logic       busy;
  } vec_t;

  vec_t vt [21];

  logic [3:0] own   [3];
  logic [6:0] ownhp [3];
  logic [3:0] cq;
  logic [3:0] eg;
  logic [6:0] eh;
  logic       ea, eb;

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, a, e);
    end
  endtask

  task automatic cyc(input logic r, input logic t, input logic [3:0] q, input logic [6:0] h);
    rst      = r;
    bus.tick = t;
    bus.req  = q;
    hp0      = h;
    @(posedge clk);
    #1;
  endtask

  task automatic outs(input string tag, input logic [3:0] g, input logic [6:0] h,
                      input logic a, input logic b);
    chk({tag, " grant"},  32'(bus.grant),  32'(g));
    chk({tag, " hp_out"}, 32'(bus.hp_out), 32'(h));
    chk({tag, " active"}, 32'(bus.active), 32'(a));
    chk({tag, " busy"},   32'(bus.busy),   32'(b));
  endtask

  initial begin
    // rst tick req hp0 | grant hp active busy
    vt[0]  = '{1'b1, 1'b0, 4'b0000, 7'd0,  4'b0000, 7'd0,  1'b0, 1'b0};
    vt[1]  = '{1'b0, 1'b0, 4'b0001, 7'd47, 4'b0001, 7'd47, 1'b1, 1'b1};
    vt[2]  = '{1'b0, 1'b1, 4'b0001, 7'd47, 4'b0001, 7'd47, 1'b1, 1'b1};
    vt[3]  = '{1'b0, 1'b0, 4'b0000, 7'd50, 4'b0001, 7'd47, 1'b1, 1'b1};
    vt[4]  = '{1'b0, 1'b1, 4'b0000, 7'd50, 4'b0000, 7'd47, 1'b0, 1'b1};
    vt[5]  = '{1'b0, 1'b0, 4'b0001, 7'd47, 4'b0000, 7'd47, 1'b0, 1'b1};
    vt[6]  = '{1'b0, 1'b1, 4'b0001, 7'd47, 4'b0000, 7'd47, 1'b0, 1'b0};
    vt[7]  = '{1'b0, 1'b0, 4'b0001, 7'd47, 4'b0001, 7'd47, 1'b1, 1'b1};
    vt[8]  = '{1'b0, 1'b0, 4'b0001, 7'd62, 4'b0001, 7'd62, 1'b1, 1'b1};
    vt[9]  = '{1'b0, 1'b1, 4'b0001, 7'd62, 4'b0001, 7'd62, 1'b1, 1'b1};
    vt[10] = '{1'b1, 1'b0, 4'b0001, 7'd62, 4'b0000, 7'd0,  1'b0, 1'b0};
    vt[11] = '{1'b0, 1'b0, 4'b0001, 7'd62, 4'b0001, 7'd62, 1'b1, 1'b1};
    vt[12] = '{1'b0, 1'b0, 4'b0000, 7'd62, 4'b0001, 7'd62, 1'b1, 1'b1};
    vt[13] = '{1'b0, 1'b1, 4'b0000, 7'd62, 4'b0001, 7'd62, 1'b1, 1'b1};
    vt[14] = '{1'b0, 1'b1, 4'b0000, 7'd62, 4'b0000, 7'd62, 1'b0, 1'b1};
    vt[15] = '{1'b0, 1'b1, 4'b0000, 7'd62, 4'b0000, 7'd62, 1'b0, 1'b0};
    vt[16] = '{1'b0, 1'b0, 4'b0100, 7'd62, 4'b0100, 7'd30, 1'b1, 1'b1};
    vt[17] = '{1'b0, 1'b0, 4'b0000, 7'd62, 4'b0100, 7'd30, 1'b1, 1'b1};
    vt[18] = '{1'b0, 1'b1, 4'b0000, 7'd62, 4'b0100, 7'd30, 1'b1, 1'b1};
    vt[19] = '{1'b0, 1'b1, 4'b0000, 7'd62, 4'b0000, 7'd30, 1'b0, 1'b1};
    vt[20] = '{1'b0, 1'b1, 4'b0000, 7'd62, 4'b0000, 7'd30, 1'b0, 1'b0};

    for (int i = 0; i < 21; i++) begin
      cyc(vt[i].rst, vt[i].tick, vt[i].req, vt[i].hp0);
      outs($sformatf("vec%0d", i), vt[i].g, vt[i].hp, vt[i].act, vt[i].busy);
    end

    // Contention with a tick every cycle: 20-tick notes, then one GAP
    // cycle and one IDLE cycle, owners alternating via the one-shot mask.
`ifdef VOICE_ARB_ROUND_ROBIN_EN
    cq    = 4'b0101;
    own   = '{4'b0001, 4'b0100, 4'b0001};
    ownhp = '{7'd47, 7'd30, 7'd47};
`else
    cq    = 4'b0011;
    own   = '{4'b0001, 4'b0010, 4'b0001};
    ownhp = '{7'd47, 7'd20, 7'd47};
`endif
    for (int k = 0; k < 45; k++) begin
      int ph;
      int n;
      ph = k % 22;
      n  = k / 22;
      cyc(1'b0, 1'b1, cq, 7'd47);
      eh = ownhp[n];
      if (ph < 20) begin
        eg = own[n]; ea = 1'b1; eb = 1'b1;
      end else begin
        eg = 4'b0000; ea = 1'b0; eb = (ph == 20);
      end
      outs($sformatf("cont k=%0d", k), eg, eh, ea, eb);
    end

    // Owner drops: natural release after MIN_HOLD, then a fresh
    // arbitration where rotating and fixed priority differ.
    cyc(1'b0, 1'b1, 4'b0000, 7'd47);
    outs("drop t1", 4'b0001, 7'd47, 1'b1, 1'b1);
    cyc(1'b0, 1'b1, 4'b0000, 7'd47);
    outs("drop t2", 4'b0000, 7'd47, 1'b0, 1'b1);
    cyc(1'b0, 1'b1, 4'b0000, 7'd47);
    outs("drop gap", 4'b0000, 7'd47, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 4'b0011, 7'd47);
`ifdef VOICE_ARB_ROUND_ROBIN_EN
    outs("prio", 4'b0010, 7'd20, 1'b1, 1'b1);
`else
    outs("prio", 4'b0001, 7'd47, 1'b1, 1'b1);
`endif

    // Reset mid-note, then a solo source well beyond MAX_HOLD
    cyc(1'b1, 1'b0, 4'b0011, 7'd47);
    outs("rst2", 4'b0000, 7'd0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 4'b1000, 7'd47);
    outs("solo grant", 4'b1000, 7'd90, 1'b1, 1'b1);
    for (int k = 0; k < 50; k++) begin
      cyc(1'b0, 1'b1, 4'b1000, 7'd47);
      chk($sformatf("solo k=%0d grant", k), 32'(bus.grant), 32'(4'b1000));
      chk($sformatf("solo k=%0d active", k), 32'(bus.active), 32'd1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
